// File: rtl/divider_taint_track.sv
// Constant-time restoring divider with per-bit taint propagation on operands and results.
// Optional divide-by-zero flag outputs are enabled by defining DIV_ZERO_FLAG_EN.
module divider_taint_track #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] dividend_t,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] divisor_t,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] quotient_t,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] remainder_t,
    output logic             quotientDone,
    output logic             quotientDone_t
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             divByZero,
    output logic             divByZero_t
`endif
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] q_q, qt_q, d_q, dt_q;
    logic [WIDTH:0]   r_q, rt_q;
    logic [CW-1:0]    cnt_q;
    logic             ctrl_t_q;

    logic [WIDTH:0]   r_sh, rt_sh, r_nx, rt_nx, smear, d_ext, dt_ext;
    logic [WIDTH-1:0] q_nx, qt_nx;
    logic             sub_ok, sel_t, acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = LOAD;
            LOAD:       state_nx = RUN;
            RUN:        if (cnt_q == LAST) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        quotientDone = (state == DONE);
    end

    // One restoring-division step; every RUN cycle does identical work for constant timing.
    always_comb begin
        d_ext  = {1'b0, d_q};
        dt_ext = {1'b0, dt_q};
        r_sh   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        rt_sh  = {rt_q[WIDTH-1:0], qt_q[WIDTH-1]};
        sub_ok = (r_sh >= d_ext);
        sel_t  = (|rt_sh) | (|dt_q);
        smear  = '0;
        acc    = 1'b0;
        for (int unsigned k = 0; k <= WIDTH; k++) begin
            acc      = acc | rt_sh[k] | dt_ext[k];
            smear[k] = acc;
        end
        r_nx  = sub_ok ? (r_sh - d_ext) : r_sh;
        q_nx  = {q_q[WIDTH-2:0], sub_ok};
        qt_nx = {qt_q[WIDTH-2:0], sel_t};
        if (sel_t)       rt_nx = '1;
        else if (sub_ok) rt_nx = smear;
        else             rt_nx = rt_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q      <= '0;
            qt_q     <= '0;
            d_q      <= '0;
            dt_q     <= '0;
            r_q      <= '0;
            rt_q     <= '0;
            cnt_q    <= '0;
            ctrl_t_q <= 1'b0;
        end else begin
            if ((state == IDLE || state == DONE) && start_t) ctrl_t_q <= 1'b1;
            case (state)
                LOAD: begin
                    q_q   <= dividend;
                    qt_q  <= dividend_t;
                    d_q   <= divisor;
                    dt_q  <= divisor_t;
                    r_q   <= '0;
                    rt_q  <= '0;
                    cnt_q <= '0;
                end
                RUN: begin
                    q_q   <= q_nx;
                    qt_q  <= qt_nx;
                    r_q   <= r_nx;
                    rt_q  <= rt_nx;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign quotient       = q_q;
    assign quotient_t     = qt_q;
    assign remainder      = r_q[WIDTH-1:0];
    assign remainder_t    = rt_q[WIDTH-1:0];
    assign quotientDone_t = ctrl_t_q;

`ifdef DIV_ZERO_FLAG_EN
    assign divByZero   = (state == DONE) && (d_q == '0);
    assign divByZero_t = (state == DONE) && (|dt_q);
`endif

endmodule

// File: doc/divider_taint_track.md
DIVIDER_TAINT_TRACK -- requirements
Module: divider_taint_track

Interface
REQ-001 Parameter: WIDTH, 128, operand width in bits; WIDTH >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start, start_t  input  1 each  begin-divide request and its taint.
REQ-005 Port: dividend, dividend_t  input  WIDTH each  numerator and its per-bit taint.
REQ-006 Port: divisor, divisor_t  input  WIDTH each  denominator and its per-bit taint.
REQ-007 Port: quotient, quotient_t  output  WIDTH each  result and its per-bit taint.
REQ-008 Port: remainder, remainder_t  output  WIDTH each  result and its per-bit taint.
REQ-009 Port: quotientDone, quotientDone_t  output  1 each  result valid and its taint.

Function
REQ-010 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-011 In IDLE or DONE, start=1 SHALL move to LOAD; start=0 SHALL hold the state.
REQ-012 In LOAD (1 cycle), the block SHALL latch dividend into Q, divisor into D (with taints), clear R (WIDTH+1 bits) and R_t, set the iteration counter to 0 and go to RUN.
REQ-013 RUN SHALL last exactly WIDTH cycles regardless of operand values (constant time), then go to DONE.
REQ-014 Each RUN cycle: R' = {R[WIDTH-1:0], Q[WIDTH-1]}, Q' = Q<<1; if R' >= D then R = R'-D and Q[0] = 1, else R = R' and Q[0] = 0.
REQ-015 Taint per RUN cycle: R_t' and Q_t' are shifted exactly like R and Q; sel_t = OR-reduce(R_t') | OR-reduce(D_t).
REQ-016 If sel_t=1: R_t = all ones and Q_t[0] = 1.
REQ-017 If sel_t=0 and a subtract occurs: R_t bit k = OR of (R_t'|D_t) bits 0..k (borrow smear), and Q_t[0] = 0.
REQ-018 If sel_t=0 and no subtract occurs: R_t = R_t' and Q_t[0] = 0.
REQ-019 quotient, remainder and their taints SHALL be driven from Q, R[WIDTH-1:0], Q_t and R_t[WIDTH-1:0] at all times.
REQ-020 quotientDone SHALL be 1 only in DONE; latency from the start-sampling edge to quotientDone=1 is WIDTH+2 edges.
REQ-021 start SHALL be ignored in LOAD and RUN.
REQ-022 start=1 in DONE SHALL restart; quotientDone SHALL drop on the next edge.
REQ-023 divisor=0 SHALL produce quotient = all ones and remainder = dividend; no special-case path is allowed.
REQ-024 A sticky control taint SHALL be set whenever start_t=1 in IDLE or DONE; quotientDone_t SHALL equal it; only rst clears it.

Reset
REQ-025 On rst=1, the block SHALL go to IDLE immediately, without waiting for a clock edge.
REQ-026 On rst=1, Q, Q_t, R, R_t, D, D_t, the counter, the control taint, quotientDone and quotientDone_t SHALL all be 0.
REQ-027 rst during LOAD or RUN SHALL abort the operation; no partial result SHALL be flagged done.

Configuration
REQ-028 With macro DIV_ZERO_FLAG_EN defined, the block SHALL add outputs divByZero and divByZero_t (1 bit each).
REQ-029 divByZero = (D==0) while in DONE, else 0.
REQ-030 divByZero_t = OR-reduce(D_t) while in DONE, else 0.
REQ-031 With DIV_ZERO_FLAG_EN undefined, those ports and their logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification (WIDTH=8)
REQ-032 100/7, all taints 0, start for 1 cycle -> after 10 edges, quotientDone=1, quotient=14, remainder=2, all taint outputs 0.
REQ-033 200/0 -> quotient=0xFF, remainder=200; with DIV_ZERO_FLAG_EN, divByZero=1.
REQ-034 divisor_t=0x80, other taints 0, 50/5 -> quotient=10, quotient_t=0xFF, remainder_t=0xFF, quotientDone_t=0.
REQ-035 start_t=1 on an accepted start -> quotientDone_t=1 in DONE; it stays 1 after a later clean start, until rst.
REQ-036 rst pulse at RUN cycle 4 -> all outputs 0 asynchronously; quotientDone stays 0 until a new start, and 9/3 then gives quotient=3, remainder=0.
REQ-037 start toggled every cycle during RUN -> ignored; the result and its timing match the single-start case.
